hwint_ctrl: RTL and testbench
=============================

# hwint_ctrl

Memory-mapped interrupt responder on the processor's data-memory port. It collects completion ("done") events from hardware units and latches them as pending bits. Software can poll the pending bits or mask them onto the `hwint` lines that feed the CP0 interrupt logic. Software acknowledges events with write-1-to-clear. The block sits beside `dmem` on the shared `memwrite`/`aluout`/`writedata`/`readdata` bus.

## Interface
- `NSRC`, 4: number of event sources, legal range 1..16.
- `BASE_ADDR`, 32'h0000_0800: register block base address; bits [3:0] are ignored.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `we` input 1: bus write strobe (processor `memwrite`).
- `addr` input 32: bus byte address (processor ALU result).
- `wdata` input 32: bus write data.
- `rdata` output 32: read data; combinational.
- `sel` output 1: address hit; the top level uses it to steer `readdata` and gate the `dmem` write enable.
- `done_in` input NSRC: done levels from hardware units, synchronous to `clk`.
- `hwint` output NSRC: masked pending bits, to CP0.
- `irq` output 1: OR-reduction of `hwint`.

## Operation
- Decode:
  - `sel` = (`addr[31:4]` == `BASE_ADDR[31:4]`).
  - Register index = `addr[3:2]`.
  - `addr[1:0]` is ignored.
- Register map:
  - 0x0 PEND: read-only. Bits [NSRC-1:0] are pending bits; upper bits read 0. Writes are ignored.
  - 0x4 MASK: read/write. Bits [NSRC-1:0] are used; upper bits are discarded on write and read 0.
  - 0x8 CLEAR: write-only, W1C on pending bits. Reads return 0.
  - 0xC COUNT: 16-bit saturating count of all events, zero-extended on read. Any write clears it.
- Edge detection:
  - `prev` is a registered copy of `done_in`.
  - rise[i] = `done_in`[i] & ~`prev`[i].
  - A level held high produces exactly one event.
- Pending update, per bit, each edge: pend_next = (pend & ~clr) | rise.
  - clr = `wdata`[NSRC-1:0] when `we` & `sel` & index 2; otherwise 0.
  - A rise and a clear on the same bit in the same cycle: the set wins, so no event is lost.
- Count update, each edge:
  - cnt_next = min(base + popcount(rise), 16'hFFFF).
  - base = 0 when a COUNT write occurs this cycle; otherwise base = cnt.
  - Count saturates and never wraps.
- `hwint` = pend & mask; `irq` = |`hwint`. Both come straight from registers and are glitch-free.
- MASK changes never alter PEND. Unmasking an already-pending bit asserts `hwint` in the cycle after the MASK write.
- When `sel` = 0: `rdata` = 0 and writes have no effect.

## Timing
- Reset values:
  - pend = 0, mask = 0, cnt = 0.
  - `prev` = all ones, so a `done_in` already high at reset release does not create an event.
  - Outputs: `hwint` = 0, `irq` = 0, `rdata` = 0 unless `sel` is asserted.
- Event latency: `done_in` rises before edge N; pend and `hwint` reflect it after edge N, i.e. one cycle.
- Reads are zero-latency (combinational from `addr`), matching `dmem` single-cycle read behaviour.
- Writes commit on the edge where `we` & `sel` is true.
- Reset asserted mid-operation clears all state immediately (asynchronous). Events that arrive while reset is held are lost.
- No handshake stalls: the block accepts every bus access in a single cycle.

## Structure
- Shared package `hwint_pkg`:
  - offset constants PEND_OFS = 2'd0, MASK_OFS = 2'd1, CLR_OFS = 2'd2, CNT_OFS = 2'd3.
  - CNT_W = 16.
  - default `BASE_ADDR`.
- One natural sub-module: `rise_det` (parameterised width; registered `prev` resetting to ones; outputs rise).
- Popcount and saturating add stay inline in `hwint_ctrl`.

## Test plan
- Reset release with `done_in` = 4'b0010 held high -> PEND = 0, COUNT = 0, `hwint` = 0 for 10 cycles.
- MASK = 4'b0101; pulse `done_in`[0] and `done_in`[1] -> next cycle PEND = 4'b0011, `hwint` = 4'b0001, `irq` = 1, COUNT = 2.
- Write CLEAR = 4'b0001 in the same cycle `done_in`[0] rises again -> PEND[0] stays 1, COUNT increments to 3.
- Write CLEAR = 4'b0011 with no new events -> PEND = 0, `irq` = 0 next cycle; a read of CLEAR returns 0.
- Force 70000 single-bit rises -> COUNT reads 16'hFFFF; a COUNT write coincident with 2 rises -> COUNT = 2.
- `addr` = `BASE_ADDR` + 32'h10 with `we` = 1 -> `sel` = 0, `rdata` = 0, all registers unchanged; assert `rst` mid-pend -> PEND, MASK, `hwint` = 0 immediately.

Source files
------------

// File: rtl/hwint_pkg.sv
// Shared constants for the hardware-event interrupt responder:
// register offsets, counter width and default base address.
package hwint_pkg;

  localparam logic [1:0] PEND_OFS = 2'd0;
  localparam logic [1:0] MASK_OFS = 2'd1;
  localparam logic [1:0] CLR_OFS  = 2'd2;
  localparam logic [1:0] CNT_OFS  = 2'd3;

  localparam int CNT_W = 16;

  localparam logic [31:0] HWINT_BASE = 32'h0000_0800;

endpackage

// File: rtl/rise_det.sv
// Rising-edge detector on W level inputs.
// Ports: clk, rst (async low), lvl in, rise out (one-cycle pulse).
module rise_det #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] lvl,
  output logic [W-1:0] rise
);

  logic [W-1:0] prev;

  // prev resets to ones so levels already high at
  // reset release are not seen as new events
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev <= '1;
    else      prev <= lvl;
  end

  assign rise = lvl & ~prev;

endmodule

// File: rtl/hwint_ctrl.sv
// Memory-mapped done-event collector: PEND/MASK/CLEAR/COUNT regs.
// Ports: bus (we, addr, wdata, rdata, sel), done_in, hwint, irq.
module hwint_ctrl
  import hwint_pkg::*;
#(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = HWINT_BASE
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic            sel,
  input  logic [NSRC-1:0] done_in,
  output logic [NSRC-1:0] hwint,
  output logic            irq
);

  logic [1:0]       idx;
  logic             wr;
  logic [NSRC-1:0]  rise;
  logic [NSRC-1:0]  clr;
  logic [NSRC-1:0]  pend;
  logic [NSRC-1:0]  pend_nxt;
  logic [NSRC-1:0]  mask;
  logic [NSRC-1:0]  mask_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_base;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W:0]   cnt_sum;
  logic [4:0]       pc;
  logic             unused;

  assign unused = ^{addr[1:0], wdata[31:NSRC]};

  assign idx = addr[3:2];
  assign sel = (addr[31:4] == BASE_ADDR[31:4]);
  assign wr  = we & sel;

  rise_det #(.W(NSRC)) u_rise (
    .clk  (clk),
    .rst  (rst),
    .lvl  (done_in),
    .rise (rise)
  );

  assign clr = (wr && idx == CLR_OFS) ? wdata[NSRC-1:0] : '0;

  // set after clear: a rise coinciding with W1C survives
  assign pend_nxt = (pend & ~clr) | rise;

  assign mask_nxt = (wr && idx == MASK_OFS) ? wdata[NSRC-1:0]
                                            : mask;

  always_comb begin
    pc = '0;
    for (int i = 0; i < NSRC; i++) begin
      pc = pc + {4'b0, rise[i]};
    end
  end

  assign cnt_base = (wr && idx == CNT_OFS) ? '0 : cnt;
  assign cnt_sum  = {1'b0, cnt_base} + {{(CNT_W-4){1'b0}}, pc};
  assign cnt_nxt  = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  // hwint/irq are registered from next-state values so they
  // track pend & mask without combinational glitches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend  <= '0;
      mask  <= '0;
      cnt   <= '0;
      hwint <= '0;
      irq   <= 1'b0;
    end else begin
      pend  <= pend_nxt;
      mask  <= mask_nxt;
      cnt   <= cnt_nxt;
      hwint <= pend_nxt & mask_nxt;
      irq   <= |(pend_nxt & mask_nxt);
    end
  end

  always_comb begin
    rdata = '0;
    if (sel) begin
      unique case (idx)
        PEND_OFS: rdata[NSRC-1:0]  = pend;
        MASK_OFS: rdata[NSRC-1:0]  = mask;
        CNT_OFS:  rdata[CNT_W-1:0] = cnt;
        default:  rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_hwint_ctrl.sv
// Randomized + directed bench for hwint_ctrl with a behavioural
// model of pend/mask/count compared every cycle.
module tb_hwint_ctrl;

  localparam int          N    = 4;
  localparam logic [31:0] BASE = 32'h0000_0800;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          we = 1'b0;
  logic [31:0]   addr = 32'h0;
  logic [31:0]   wdata = 32'h0;
  logic [31:0]   rdata;
  logic          sel;
  logic [N-1:0]  done_in = 4'b0010;
  logic [N-1:0]  hwint;
  logic          irq;

  int n_chk = 0;
  int n_fail = 0;

  hwint_ctrl #(.NSRC(N), .BASE_ADDR(BASE)) dut (
    .clk     (clk),
    .rst     (rst),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .sel     (sel),
    .done_in (done_in),
    .hwint   (hwint),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  // behavioural model
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_prev = '1;
  int           m_cnt  = 0;
  logic [N-1:0] m_clr;
  logic [N-1:0] m_rise;
  int           m_nr;
  int           m_base;
  bit           m_hit;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_pend = '0;
      m_mask = '0;
      m_prev = '1;
      m_cnt  = 0;
    end else begin
      m_hit = (addr[31:4] == BASE[31:4]);
      m_nr  = 0;
      for (int i = 0; i < N; i++) begin
        m_rise[i] = done_in[i] && !m_prev[i];
        if (m_rise[i]) m_nr++;
      end
      m_clr  = (we && m_hit && addr[3:2] == 2) ? wdata[N-1:0] : '0;
      m_base = (we && m_hit && addr[3:2] == 3) ? 0 : m_cnt;
      m_cnt  = (m_base + m_nr > 65535) ? 65535 : m_base + m_nr;
      if (we && m_hit && addr[3:2] == 1) m_mask = wdata[N-1:0];
      m_pend = (m_pend & ~m_clr) | m_rise;
      m_prev = done_in;
    end
  end

  function automatic logic [31:0] m_rdata(input logic [31:0] a);
    logic [31:0] r;
    r = 32'h0;
    if (a[31:4] == BASE[31:4]) begin
      case (a[3:2])
        2'd0: r = {28'h0, m_pend};
        2'd1: r = {28'h0, m_mask};
        2'd3: r = m_cnt;
        default: r = 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("hwint", {28'h0, hwint}, {28'h0, m_pend & m_mask});
      chk("irq", {31'h0, irq}, {31'h0, |(m_pend & m_mask)});
      chk("sel", {31'h0, sel},
          {31'h0, addr[31:4] == BASE[31:4]});
      chk("rdata", rdata, m_rdata(addr));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bwr(input logic [1:0] ofs, input logic [31:0] d);
    we    = 1'b1;
    addr  = BASE + {28'h0, ofs, 2'b00};
    wdata = d;
    tick();
    we    = 1'b0;
  endtask

  task automatic brd(input logic [1:0] ofs, output logic [31:0] d);
    addr = BASE + {28'h0, ofs, 2'b00};
    #1;
    d = rdata;
  endtask

  logic [31:0] rv;
  int          r;

  initial begin
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;

    // done_in[1] held across reset release: no event
    for (int i = 0; i < 10; i++) begin
      tick();
      brd(2'd0, rv); chk("rst_pend", rv, 32'h0);
      brd(2'd3, rv); chk("rst_cnt", rv, 32'h0);
      chk("rst_hwint", {28'h0, hwint}, 32'h0);
    end

    bwr(2'd1, 32'hFFFF_FFF5);
    brd(2'd1, rv); chk("mask_rd", rv, 32'h5);
    done_in = 4'b0000; tick();
    done_in = 4'b0011; tick();
    brd(2'd0, rv); chk("pend_2ev", rv, 32'h3);
    chk("hwint_2ev", {28'h0, hwint}, 32'h1);
    chk("irq_2ev", {31'h0, irq}, 32'h1);
    brd(2'd3, rv); chk("cnt_2ev", rv, 32'h2);
    done_in = 4'b0000; tick();

    // clear and re-rise on bit 0 in the same cycle
    done_in = 4'b0001;
    bwr(2'd2, 32'h1);
    brd(2'd0, rv); chk("pend_setwins", rv, 32'h3);
    brd(2'd3, rv); chk("cnt_3", rv, 32'h3);
    done_in = 4'b0000; tick();

    bwr(2'd2, 32'h3);
    brd(2'd0, rv); chk("pend_clr", rv, 32'h0);
    chk("irq_clr", {31'h0, irq}, 32'h0);
    brd(2'd2, rv); chk("clr_rd", rv, 32'h0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      done_in = 4'($urandom);
      r = $urandom_range(0, 9);
      if (r < 7)
        addr = BASE + {28'h0, 2'($urandom), 2'($urandom)};
      else if (r < 9)
        addr = BASE + 32'h10 + {28'h0, 4'($urandom)};
      else
        addr = $urandom;
      we    = ($urandom_range(0, 2) == 0);
      wdata = $urandom;
      tick();
    end
    we = 1'b0;

    // saturation: 35000 cycles x 2 rises each
    done_in = 4'b0000;
    bwr(2'd3, 32'h0);
    brd(2'd3, rv); chk("cnt_zero", rv, 32'h0);
    addr = BASE + 32'hC;
    for (int i = 0; i < 35000; i++) begin
      done_in = i[0] ? 4'b1010 : 4'b0101;
      tick();
    end
    brd(2'd3, rv); chk("cnt_sat", rv, 32'hFFFF);
    done_in = ~done_in;
    bwr(2'd3, 32'h1234_5678);
    brd(2'd3, rv); chk("cnt_wr_2rise", rv, 32'h2);
    brd(2'd0, rv); chk("pend_all", rv, 32'hF);

    bwr(2'd1, 32'h6);
    chk("hwint_0110", {28'h0, hwint}, 32'h6);

    // out-of-window write must be ignored
    we    = 1'b1;
    addr  = BASE + 32'h10;
    wdata = 32'hFFFF_FFFF;
    #1;
    chk("oow_sel", {31'h0, sel}, 32'h0);
    chk("oow_rdata", rdata, 32'h0);
    tick();
    we = 1'b0;
    brd(2'd0, rv); chk("oow_pend", rv, 32'hF);
    brd(2'd1, rv); chk("oow_mask", rv, 32'h6);
    brd(2'd3, rv); chk("oow_cnt", rv, 32'h2);

    // asynchronous reset mid-operation
    rst = 1'b0;
    #1;
    chk("arst_hwint", {28'h0, hwint}, 32'h0);
    chk("arst_irq", {31'h0, irq}, 32'h0);
    brd(2'd0, rv); chk("arst_pend", rv, 32'h0);
    brd(2'd1, rv); chk("arst_mask", rv, 32'h0);
    done_in = 4'b0000;
    tick();
    done_in = 4'b1111;
    tick();
    rst = 1'b1;
    tick();
    brd(2'd0, rv); chk("post_rst_pend", rv, 32'h0);
    brd(2'd3, rv); chk("post_rst_cnt", rv, 32'h0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
